// File: rtl/project_types.sv
// Shared types for the front end of the pipeline.
//   inst_addr_t / inst_t : default-width PC and instruction word
//   fq_entry_t           : one fetch-queue slot, {pc, inst}
//   NOP_INST             : all-zero instruction used as a decode bubble
package project_types;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fq_entry_t;

  localparam inst_t NOP_INST = '0;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage array for fetch_queue: DEPTH entries, one synchronous write port and one asynchronous
// read port. The array is deliberately not reset; validity is tracked by the owner's counter.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : read data (combinational)
module fetch_queue_mem
  import project_types::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fq_entry_t,
  localparam int unsigned PtrW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [PtrW-1:0] waddr_i,
  input  entry_t          wdata_i,
  input  logic [PtrW-1:0] raddr_i,
  output entry_t          rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between IF and ID: a DEPTH-entry FIFO of {pc, inst} pairs with valid/ready
// handshakes on both sides and a one-cycle flush for redirects. When empty, decode sees a zeroed
// NOP bubble.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an entry arriving at an empty queue reach
// deq_* in the same cycle; without it there is no path from enq_* to deq_*.
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : discard all entries at the next edge
//   enq_valid_i   : fetch presents enq_pc_i / enq_inst_i
//   enq_ready_o   : queue not full
//   deq_valid_o   : head entry valid
//   deq_ready_i   : decode consumes the head
//   deq_pc_o      : head PC, 0 when not valid
//   deq_inst_o    : head instruction, NOP when not valid
//   count_o       : occupancy 0..DEPTH
module fetch_queue
  import project_types::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [ADDR_W-1:0] enq_pc_i,
  input  logic [INST_W-1:0] enq_inst_i,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [ADDR_W-1:0] deq_pc_o,
  output logic [INST_W-1:0] deq_inst_o,
  output logic [CntW-1:0]   count_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic   full, empty;
  logic   bypass_active, bypass_take;
  logic   do_push, do_pop;
  entry_t wdata, rdata;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Derived from registered state only, so it never depends on deq_ready_i.
  assign enq_ready_o = ~full;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_active = empty & enq_valid_i & ~flush_i;
`else
  assign bypass_active = 1'b0;
`endif
  // A bypassed entry that decode takes immediately is never written.
  assign bypass_take = bypass_active & deq_ready_i;

  assign do_push = enq_valid_i & enq_ready_o & ~bypass_take;
  assign do_pop  = ~empty & deq_ready_i;

  assign wdata.pc   = enq_pc_i;
  assign wdata.inst = enq_inst_i;

  fetch_queue_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_push & ~flush_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    deq_valid_o = 1'b0;
    deq_pc_o    = '0;
    deq_inst_o  = INST_W'(NOP_INST);
    if (!empty) begin
      deq_valid_o = 1'b1;
      deq_pc_o    = rdata.pc;
      deq_inst_o  = rdata.inst;
    end else if (bypass_active) begin
      deq_valid_o = 1'b1;
      deq_pc_o    = enq_pc_i;
      deq_inst_o  = enq_inst_i;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [31:0] enq_pc_i;
  logic [31:0] enq_inst_i;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_inst_o;
  logic [2:0]  count_o;

  fetch_queue #(
    .DEPTH  (4),
    .ADDR_W (32),
    .INST_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .enq_pc_i    (enq_pc_i),
    .enq_inst_i  (enq_inst_i),
    .deq_valid_o (deq_valid_o),
    .deq_ready_i (deq_ready_i),
    .deq_pc_o    (deq_pc_o),
    .deq_inst_o  (deq_inst_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] exp_q [$];
  logic        pending_clear = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]} ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a pop fires at the coming edge when valid&ready and not flushed/reset.
  always @(negedge clk) begin
    if (!rst && !flush_i && deq_valid_o && deq_ready_i) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got pc 0x%08h, expected no entry", deq_pc_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({deq_pc_o, deq_inst_o} !== e) begin
          n_fail++;
          $display("FAIL deq_order: got pc 0x%08h inst 0x%08h, expected pc 0x%08h inst 0x%08h",
                   deq_pc_o, deq_inst_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  // One cycle: inputs applied just after the edge, returns at the negedge for checks.
  task automatic cyc(input logic ev, input logic [31:0] pc, input logic dr, input logic fl,
                     input logic rs, input logic exp_push);
    @(posedge clk);
    #1;
    if (pending_clear) begin
      exp_q.delete();
      pending_clear = 1'b0;
    end
    enq_valid_i = ev;
    enq_pc_i    = pc;
    enq_inst_i  = inst_of(pc);
    deq_ready_i = dr;
    flush_i     = fl;
    rst         = rs;
    if (exp_push) exp_q.push_back({pc, inst_of(pc)});
    if (fl || rs) pending_clear = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input logic dr);
    cyc(1'b0, 32'h0, dr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},     32'(count_o),     32'd0);
    chk({tag, "_enq_ready"}, 32'(enq_ready_o), 32'd1);
    chk({tag, "_deq_valid"}, 32'(deq_valid_o), 32'd0);
    chk({tag, "_deq_pc"},    deq_pc_o,         32'd0);
    chk({tag, "_deq_inst"},  deq_inst_o,       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
    enq_pc_i = '0; enq_inst_i = '0;

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk_reset_state("reset");

    // Fill to DEPTH, then attempt a fifth push.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_enq_ready", 32'(enq_ready_o), 32'd0);
    cyc(1'b1, 32'h110, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_enq_ready_push", 32'(enq_ready_o), 32'd0);
    idle(1'b0);
    chk("full_drop_count", 32'(count_o), 32'd4);
    chk("full_head_pc", deq_pc_o, 32'h100);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);
    chk("drained_count", 32'(count_o), 32'd0);
    chk("drained_valid", 32'(deq_valid_o), 32'd0);

    // Steady stream at count=2 across pointer wrap.
    cyc(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'h408 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b1);
      chk("stream_count", 32'(count_o), 32'd2);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("stream_end_count", 32'(count_o), 32'd0);

    // Flush at count=3 with simultaneous push.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("preflush_count", 32'(count_o), 32'd3);
    cyc(1'b1, 32'h5FC, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(deq_valid_o), 32'd0);
    idle(1'b1);
    chk("flush_valid2", 32'(deq_valid_o), 32'd0);
    chk("flush_pc", deq_pc_o, 32'd0);

    // Push into empty queue with decode ready.
    cyc(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid", 32'(deq_valid_o), 32'd1);
    chk("byp_pc", deq_pc_o, 32'h200);
    chk("byp_count", 32'(count_o), 32'd0);
    idle(1'b1);
    chk("byp_after_count", 32'(count_o), 32'd0);
    chk("byp_after_valid", 32'(deq_valid_o), 32'd0);
`else
    chk("nobyp_valid", 32'(deq_valid_o), 32'd0);
    chk("nobyp_pc", deq_pc_o, 32'd0);
    idle(1'b1);
    chk("nobyp_count", 32'(count_o), 32'd1);
    chk("nobyp_pc_late", deq_pc_o, 32'h200);
`endif
    idle(1'b0);
    chk("byp_end_count", 32'(count_o), 32'd0);

    // Reset mid-stream at count=2.
    cyc(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h608, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("prerst_count", 32'(count_o), 32'd2);
    cyc(1'b1, 32'h60C, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk_reset_state("midrst");
    idle(1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
